// File: rtl/ksz_reg_sequencer.sv
// Register command front-end for the KSZ8851 IO engine: read, write and atomic set/clear bits.
// Optional KSZ_SEQ_TIMEOUT_EN bounds each IO-engine transaction to TIMEOUT_CYCLES and reports rsp_err.
module ksz_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_offset,
  input  logic        req_length,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        rio_WR,
  output logic [7:0]  rio_offset,
  output logic        rio_length,
  output logic [15:0] rio_writeData,
  output logic        rio_NewCommand,
  output logic        rio_Dummy_Write,
  output logic        rio_Dummy_Read,
  input  logic [15:0] rio_readData,
  input  logic [3:0]  rio_state
);
  localparam logic [3:0] RIO_WAIT = 4'h9;

  typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, MODIFY, ISSUE_WR, WAIT_WR, RESP} state_t;
  state_t state, state_nxt;

  logic [1:0]  op_q;
  logic [7:0]  off_q;
  logic        len_q;
  logic [15:0] data_q, rd_q, wdata_q, mod_val;
  logic        seen_busy, eng_idle, in_wait, issue, done, timeout, rsp_load;

  assign eng_idle = (rio_state == RIO_WAIT);
  assign in_wait  = (state == WAIT_RD) || (state == WAIT_WR);
  assign issue    = ((state == ISSUE_RD) || (state == ISSUE_WR)) && eng_idle;
  // seen_busy is registered, so the cycle right after issue can never complete
  assign done     = in_wait && eng_idle && seen_busy;
  assign rsp_load = done && ((state == WAIT_WR) || (op_q == 2'd0));

  always_comb begin
    mod_val = (op_q == 2'd2) ? (rd_q | data_q) : (rd_q & ~data_q);
    if (!len_q) mod_val[15:8] = 8'h00;
  end

`ifdef KSZ_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)       to_cnt <= '0;
    else if (issue)   to_cnt <= '0;
    else if (in_wait) to_cnt <= to_cnt + TW'(1);
  end

  assign timeout = in_wait && !done && (to_cnt == TO_LAST);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)        rsp_err <= 1'b0;
    else if (rsp_load) rsp_err <= 1'b0;
    else if (timeout)  rsp_err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid) state_nxt = (req_op == 2'd1) ? ISSUE_WR : ISSUE_RD;
      ISSUE_RD: if (eng_idle) state_nxt = WAIT_RD;
      WAIT_RD:  if (done) state_nxt = (op_q == 2'd0) ? RESP : MODIFY;
                else if (timeout) state_nxt = RESP;
      MODIFY:   state_nxt = ISSUE_WR;
      ISSUE_WR: if (eng_idle) state_nxt = WAIT_WR;
      WAIT_WR:  if (done || timeout) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op_q           <= 2'd0;
      off_q          <= 8'h00;
      len_q          <= 1'b0;
      data_q         <= 16'h0000;
      rd_q           <= 16'h0000;
      wdata_q        <= 16'h0000;
      seen_busy      <= 1'b0;
      rio_NewCommand <= 1'b0;
      rsp_data       <= 16'h0000;
    end else begin
      state          <= state_nxt;
      rio_NewCommand <= issue;
      if (issue)                    seen_busy <= 1'b0;
      else if (in_wait && !eng_idle) seen_busy <= 1'b1;
      if ((state == IDLE) && req_valid) begin
        op_q    <= req_op;
        off_q   <= req_offset;
        len_q   <= req_length;
        data_q  <= req_data;
        wdata_q <= req_length ? req_data : {8'h00, req_data[7:0]};
      end
      if (state == MODIFY) wdata_q <= mod_val;
      if ((state == WAIT_RD) && done) rd_q <= rio_readData;
      if (rsp_load)     rsp_data <= (state == WAIT_WR) ? wdata_q : rio_readData;
      else if (timeout) rsp_data <= 16'h0000;
    end
  end

  assign req_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign rsp_valid       = (state == RESP);
  assign rio_WR          = (state == ISSUE_WR) || (state == WAIT_WR);
  assign rio_offset      = off_q;
  assign rio_length      = len_q;
  assign rio_writeData   = wdata_q;
  assign rio_Dummy_Write = 1'b0;
  assign rio_Dummy_Read  = 1'b0;
endmodule
